// File: rtl/fetch_buffer.sv
// Circular instruction queue between the multi-way fetch stage and decode.
// Enqueues up to WAY_NUM leading-valid lanes per cycle and presents the oldest WAY_NUM entries in order.
module fetch_buffer #(
  parameter int WAY_NUM = 2,
  parameter int DEPTH   = 8,
  parameter int XLEN    = 32
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           squash,
  input  logic [WAY_NUM-1:0]             if_valid_inst_in,
  input  logic [WAY_NUM*XLEN-1:0]        if_NPC_in,
  input  logic [WAY_NUM*32-1:0]          if_IR_in,
  input  logic [$clog2(WAY_NUM+1)-1:0]   id_take_cnt,
  output logic                           fb_ready,
  output logic [WAY_NUM*XLEN-1:0]        fb_NPC_out,
  output logic [WAY_NUM*32-1:0]          fb_IR_out,
  output logic [WAY_NUM-1:0]             fb_valid_inst_out,
  output logic [$clog2(DEPTH+1)-1:0]     fb_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [XLEN-1:0]  npc_mem [DEPTH];
  logic [31:0]      ir_mem  [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic [CNT_W-1:0] n_in;
  logic [CNT_W-1:0] n_in_acc;
  logic [CNT_W-1:0] n_out;
  logic [CNT_W-1:0] take_ext;
  logic             lead_run;
  logic             accept;

  // Only the contiguous run of valid lanes starting at lane 0 is accepted.
  always_comb begin
    n_in     = '0;
    lead_run = 1'b1;
    for (int i = 0; i < WAY_NUM; i++) begin
      lead_run = lead_run & if_valid_inst_in[i];
      if (lead_run) n_in = n_in + CNT_W'(1);
    end
  end

  always_comb begin
    take_ext = CNT_W'(id_take_cnt);
    n_out    = (take_ext > count) ? count : take_ext;
  end

  // Ready looks at registered occupancy only, so it never depends on this cycle's take.
  assign fb_ready = (CNT_W'(DEPTH) - count) >= CNT_W'(WAY_NUM);
  assign accept   = fb_ready & ~squash;
  assign n_in_acc = accept ? n_in : '0;
  assign fb_count = count;

  always_ff @(posedge clock) begin
    for (int i = 0; i < WAY_NUM; i++) begin
      if (accept && (CNT_W'(i) < n_in)) begin
        npc_mem[tail + PTR_W'(i)] <= if_NPC_in[i*XLEN +: XLEN];
        ir_mem[tail + PTR_W'(i)]  <= if_IR_in[i*32 +: 32];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (squash) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(n_out);
      tail  <= tail + PTR_W'(n_in_acc);
      count <= count + n_in_acc - n_out;
    end
  end

  // Lanes beyond the occupancy are forced to zero so stale storage never leaks out.
  always_comb begin
    fb_valid_inst_out = '0;
    fb_NPC_out        = '0;
    fb_IR_out         = '0;
    for (int i = 0; i < WAY_NUM; i++) begin
      if (count > CNT_W'(i)) begin
        fb_valid_inst_out[i]      = 1'b1;
        fb_NPC_out[i*XLEN +: XLEN] = npc_mem[head + PTR_W'(i)];
        fb_IR_out[i*32 +: 32]      = ir_mem[head + PTR_W'(i)];
      end
    end
  end

  a_count_bound: assert property (@(posedge clock) disable iff (reset)
    count <= CNT_W'(DEPTH));
  a_take_bound: assert property (@(posedge clock) disable iff (reset)
    n_out <= count);

endmodule
